// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and helpers for the memory responder.
// Holds the FSM state enum, counter width and the address window check.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_t;

    localparam int LAT_CNT_BITS = 4;

    // True when addr lies in [base, base + 4*2**addr_bits - 1].
    // Bit 32 of the 33-bit difference is the borrow for addr < base.
    function automatic logic in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned addr_bits
    );
        logic [32:0] off;
        logic [32:0] lim;
        off = {1'b0, addr} - {1'b0, base};
        lim = 33'd4 << addr_bits;
        return !off[32] && (off < lim);
    endfunction

endpackage

// File: rtl/mem_if.sv
// mem_if: CPU single-port word memory bus.
// master = core (drives requests), slave = memory (drives resp/rdata).
interface mem_if;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_resp,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_resp,
        output mem_rdata
    );

endinterface

// File: rtl/mem_bram_be.sv
// mem_bram_be: single-port word RAM, registered read, 4 byte lanes.
// Ports: clk, addr (word index), we (lane enables), wdata, rdata.
module mem_bram_be #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [3:0]           we,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder backed by a word RAM.
// Ports: clk, rst (async, active-low), bus (mem_if.slave), busy, err.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LATENCY   = 3
) (
    input  logic  clk,
    input  logic  rst,
    mem_if.slave  bus,
    output logic  busy,
    output logic  err
);

    mem_resp_state_t state_q, state_d;

    logic [LAT_CNT_BITS-1:0] cnt_q;
    logic                    rd_q;
    logic                    wr_q;
    logic                    bad_q;
    logic [ADDR_BITS-1:0]    idx_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;

    logic                 accept;
    logic                 bad_in;
    logic                 abort;
    logic [ADDR_BITS-1:0] in_idx;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [3:0]           ram_we;
    logic [31:0]          ram_q;

    assign accept = bus.mem_read | bus.mem_write;
    assign bad_in = (bus.mem_read & bus.mem_write)
                  | !in_window(bus.mem_address, BASE_ADDR, ADDR_BITS);
    assign in_idx = ADDR_BITS'((bus.mem_address - BASE_ADDR) >> 2);

    // Request lines must stay exactly as they were at acceptance.
    assign abort = ({bus.mem_read, bus.mem_write} != {rd_q, wr_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
            WAIT: begin
                if (abort)
                    state_d = IDLE;
                else if (cnt_q == LAT_CNT_BITS'(1))
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        bus.mem_resp  = (state_q == RESP);
        // In IDLE the RAM reads the incoming index so LATENCY=1 works.
        ram_addr      = (state_q == IDLE) ? in_idx : idx_q;
        ram_we        = (state_q == RESP && wr_q && !bad_q) ? be_q : 4'b0;
        bus.mem_rdata = (state_q == RESP && rd_q && !bad_q) ? ram_q : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err     <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            cnt_q   <= LAT_CNT_BITS'(LATENCY - 1);
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            bad_q   <= bad_in;
            idx_q   <= in_idx;
            be_q    <= bus.mem_byte_enable;
            wdata_q <= bus.mem_wdata;
            if (bad_in) err <= 1'b1;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - LAT_CNT_BITS'(1);
            if (abort) err <= 1'b1;
        end
    end

    mem_bram_be #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder.
// Instance a has LATENCY=3, instance b has LATENCY=1.
module tb_mem_responder;

    logic clk;
    logic rst;
    logic busy_a, err_a;
    logic busy_b, err_b;

    int n_chk  = 0;
    int n_fail = 0;

    mem_if ifa ();
    mem_if ifb ();

    mem_responder #(.LATENCY(3)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifa),
        .busy (busy_a),
        .err  (err_a)
    );

    mem_responder #(.LATENCY(1)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifb),
        .busy (busy_b),
        .err  (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input bit rd, input bit wr,
                         input logic [31:0] addr,
                         input logic [3:0] be,
                         input logic [31:0] wd);
        if (b) begin
            ifb.mem_read        = rd;
            ifb.mem_write       = wr;
            ifb.mem_address     = addr;
            ifb.mem_byte_enable = be;
            ifb.mem_wdata       = wd;
        end else begin
            ifa.mem_read        = rd;
            ifa.mem_write       = wr;
            ifa.mem_address     = addr;
            ifa.mem_byte_enable = be;
            ifa.mem_wdata       = wd;
        end
    endtask

    function automatic logic cur_resp(input bit b);
        return b ? ifb.mem_resp : ifa.mem_resp;
    endfunction

    function automatic logic [31:0] cur_rdata(input bit b);
        return b ? ifb.mem_rdata : ifa.mem_rdata;
    endfunction

    // lat = posedge count from acceptance edge (1) to resp seen; 0 = timeout.
    task automatic xact(input bit b, input bit rd, input bit wr,
                        input logic [31:0] addr,
                        input logic [3:0] be,
                        input logic [31:0] wd,
                        output logic [31:0] rdata,
                        output int lat);
        lat   = 0;
        rdata = 32'h0;
        @(negedge clk);
        drive(b, rd, wr, addr, be, wd);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (cur_resp(b)) begin
                lat   = i;
                rdata = cur_rdata(b);
                break;
            end
        end
        drive(b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    int          lat;
    bit          seen;

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp",  32'(ifa.mem_resp), 32'h0);
        chk("rst_rdata", ifa.mem_rdata,     32'h0);
        chk("rst_busy",  32'(busy_a),       32'h0);
        chk("rst_err",   32'(err_a),        32'h0);
        @(negedge clk);
        rst = 1'b1;

        // basic write then read
        xact(0, 0, 1, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, rd, lat);
        chk("wr_lat", 32'(lat), 32'd3);
        xact(0, 1, 0, 32'h4000_0010, 4'h0, 32'h0, rd, lat);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_err", 32'(err_a), 32'h0);

        // byte lanes
        xact(0, 0, 1, 32'h4000_0020, 4'hF, 32'h1122_3344, rd, lat);
        xact(0, 0, 1, 32'h4000_0020, 4'h5, 32'hAABB_CCDD, rd, lat);
        xact(0, 1, 0, 32'h4000_0020, 4'h0, 32'h0, rd, lat);
        chk("be0101", rd, 32'h11BB_33DD);
        xact(0, 0, 1, 32'h4000_0020, 4'h0, 32'hFFFF_FFFF, rd, lat);
        chk("be0000_lat", 32'(lat), 32'd3);
        xact(0, 1, 0, 32'h4000_0020, 4'h0, 32'h0, rd, lat);
        chk("be0000", rd, 32'h11BB_33DD);

        // out-of-window and double request
        xact(0, 0, 1, 32'h4000_0000, 4'hF, 32'hCAFE_F00D, rd, lat);
        chk("pre_oow_err", 32'(err_a), 32'h0);
        xact(0, 1, 0, 32'h3FFF_FFFC, 4'h0, 32'h0, rd, lat);
        chk("oow_rd_lat", 32'(lat), 32'd3);
        chk("oow_rd_data", rd, 32'h0);
        chk("oow_err", 32'(err_a), 32'h1);
        xact(0, 0, 1, 32'h4000_1000, 4'hF, 32'h5555_5555, rd, lat);
        chk("oow_wr_lat", 32'(lat), 32'd3);
        xact(0, 1, 0, 32'h4000_0000, 4'h0, 32'h0, rd, lat);
        chk("oow_ram", rd, 32'hCAFE_F00D);
        xact(0, 1, 1, 32'h4000_0020, 4'hF, 32'h0, rd, lat);
        chk("both_lat", 32'(lat), 32'd3);
        chk("both_data", rd, 32'h0);
        xact(0, 1, 0, 32'h4000_0020, 4'h0, 32'h0, rd, lat);
        chk("both_ram", rd, 32'h11BB_33DD);

        // reset in WAIT aborts pending write
        @(negedge clk);
        drive(0, 0, 1, 32'h4000_0010, 4'hF, 32'h1234_5678);
        @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy_a), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_resp",  32'(ifa.mem_resp), 32'h0);
        chk("mid_rst_rdata", ifa.mem_rdata,     32'h0);
        chk("mid_rst_busy",  32'(busy_a),       32'h0);
        chk("mid_rst_err",   32'(err_a),        32'h0);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        xact(0, 1, 0, 32'h4000_0010, 4'h0, 32'h0, rd, lat);
        chk("rst_ram", rd, 32'hDEAD_BEEF);
        chk("rst_err_clr", 32'(err_a), 32'h0);

        // request dropped in WAIT
        @(negedge clk);
        drive(0, 1, 0, 32'h4000_0010, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("abort_busy0", 32'(busy_a), 32'h1);
        drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ifa.mem_resp) seen = 1'b1;
        end
        chk("abort_resp", 32'(seen), 32'h0);
        chk("abort_busy", 32'(busy_a), 32'h0);
        chk("abort_err", 32'(err_a), 32'h1);
        xact(0, 1, 0, 32'h4000_0010, 4'h0, 32'h0, rd, lat);
        chk("post_abort_lat", 32'(lat), 32'd3);
        chk("post_abort_data", rd, 32'hDEAD_BEEF);

        // LATENCY=1 back-to-back reads
        xact(1, 0, 1, 32'h4000_0100, 4'hF, 32'd1, rd, lat);
        chk("l1_wr_lat", 32'(lat), 32'd1);
        xact(1, 0, 1, 32'h4000_0104, 4'hF, 32'd2, rd, lat);
        xact(1, 0, 1, 32'h4000_0108, 4'hF, 32'd3, rd, lat);
        @(negedge clk);
        drive(1, 1, 0, 32'h4000_0100, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b_resp%0d", k), 32'(ifb.mem_resp), 32'h1);
            chk($sformatf("b2b_busy%0d", k), 32'(busy_b), 32'h1);
            chk($sformatf("b2b_data%0d", k), ifb.mem_rdata, 32'(k + 1));
            if (k < 2)
                drive(1, 1, 0, 32'h4000_0104 + 32'(4 * k), 4'h0, 32'h0);
            else
                drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b_gap_resp%0d", k), 32'(ifb.mem_resp), 32'h0);
            chk($sformatf("b2b_gap_busy%0d", k), 32'(busy_b), 32'h0);
            chk($sformatf("b2b_gap_rdata%0d", k), ifb.mem_rdata, 32'h0);
        end
        chk("l1_err", 32'(err_b), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
